// File: rtl/fir_sample_feeder.sv
// fir_sample_feeder: FIFO-buffered, period-paced sample source for the FIR din/rfd input.
// Issues one sample per PERIOD clocks, stalls on rfd, zero-fills on underrun.
module fir_sample_feeder #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int PERIOD = 1134,
    parameter int CNT_W  = 11,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     wr_en,
    input  logic signed [DATA_W-1:0] wr_data,
    output logic                     full,
    output logic [LW-1:0]            level,
    input  logic                     rfd,
    output logic signed [DATA_W-1:0] din,
    output logic                     nd,
    output logic [15:0]              underrun_cnt,
    output logic [15:0]              late_cnt,
    output logic                     ovf
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
    localparam logic [LW-1:0]    LVL_FULL = LW'(DEPTH);

    typedef enum logic {IDLE, PEND} state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic signed [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]            wr_ptr;
    logic [AW-1:0]            rd_ptr;
    logic [CNT_W-1:0]         cnt;
    state_t                   state;
    logic                     tick;
    logic                     empty;
    logic                     push;
    logic                     pop;
    logic                     vld_p0;
    logic                     late_p0;
    logic signed [DATA_W-1:0] dat_p0;

    // full compares the registered level, so a write in a popping cycle still sees full
    assign full  = (level == LVL_FULL);
    assign empty = (level == '0);
    assign tick  = en && (cnt == CNT_LAST);
    assign push  = wr_en && !full;
    assign pop   = vld_p0 && !empty;

    // stage p0: issue decision and head/zero-fill selection
    always_comb begin
        vld_p0  = 1'b0;
        late_p0 = 1'b0;
        if (en) begin
            case (state)
                IDLE: vld_p0 = tick && rfd;
                PEND: begin
                    vld_p0  = rfd;
                    late_p0 = tick;
                end
            endcase
        end
        dat_p0 = empty ? '0 : mem[rd_ptr];
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
            if (wr_en && full) begin
                ovf <= 1'b1;
            end
        end
    end

    // stage p1: registered issue (nd/din), pacing counter, issue FSM and event counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            state        <= IDLE;
            nd           <= 1'b0;
            din          <= '0;
            underrun_cnt <= '0;
            late_cnt     <= '0;
        end else begin
            if (!en || cnt == CNT_LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end

            if (!en) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: if (tick && !rfd) state <= PEND;
                    PEND: if (rfd) state <= IDLE;
                endcase
            end

            nd <= vld_p0;
            if (vld_p0) begin
                din <= dat_p0;
            end
            if (vld_p0 && empty) begin
                underrun_cnt <= sat_inc(underrun_cnt);
            end
            if (late_p0) begin
                late_cnt <= sat_inc(late_cnt);
            end
        end
    end

endmodule

// File: doc/fir_sample_feeder.md
# fir_sample_feeder

Rate-paced sample source for the input side of the FIR filter, driving the filter's `din`/`rfd` interface. A host or bench writes 16-bit samples into a small FIFO at any rate; the feeder releases exactly one sample per sample period to the filter and waits for `rfd` if the filter is busy. It zero-fills on underrun and counts late and dropped events. Default period is 1134 clocks (44.1 kHz at a 50 MHz clock).

## Interface

- `DATA_W`, 16: sample width.
- `DEPTH`, 16: FIFO depth in words; power of two, at least 2.
- `PERIOD`, 1134: clocks per sample period; at least 2.
- `CNT_W`, 11: period counter width; must satisfy 2^CNT_W ≥ PERIOD.
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `en`, in, 1: pacing enable.
- `wr_en`, in, 1: push `wr_data` into the FIFO.
- `wr_data`, in, DATA_W: sample to push.
- `full`, out, 1: FIFO full.
- `level`, out, log2(DEPTH)+1: FIFO occupancy, 0..DEPTH.
- `rfd`, in, 1: filter ready for data.
- `din`, out, DATA_W: sample presented to the filter; held between issues.
- `nd`, out, 1: one-cycle strobe marking a new `din`.
- `underrun_cnt`, out, 16: zero-filled issues; saturates at 0xFFFF.
- `late_cnt`, out, 16: periods that elapsed while an issue was pending; saturates.
- `ovf`, out, 1: sticky flag; a write was dropped.

## Operation

**Reset values.** `din`=0, `nd`=0, `full`=0, `level`=0, `underrun_cnt`=0, `late_cnt`=0, `ovf`=0. The period counter is 0, pending is clear, and the FIFO pointers are 0. A reset mid-operation discards FIFO contents and any pending issue.

**FIFO.**
- Standard circular buffer with DEPTH-wrapping pointers.
- A write with `full`=1 is dropped and sets `ovf`. This holds even if a pop occurs in the same cycle, because `full` is the pre-edge value.
- A simultaneous write and pop on a non-full, non-empty FIFO leaves `level` unchanged.

**Period counter.**
- While `en`=1: cnt ← (cnt==PERIOD-1) ? 0 : cnt+1.
- While `en`=0: cnt ← 0 and pending ← 0.
- `tick` = `en` && cnt==PERIOD-1.

**Issue FSM.** States IDLE and PEND.
- **IDLE**
  - `tick` && `rfd` → issue, stay in IDLE.
  - `tick` && !`rfd` → PEND.
- **PEND**
  - `rfd` → issue, go to IDLE.
  - If `tick` and `rfd` are both high in PEND, issue once, go to IDLE, and increment `late_cnt`. The new tick is absorbed; it is never issued twice.
  - `tick` && !`rfd` → increment `late_cnt`, stay in PEND.
  - `en`=0 → IDLE.
- **Issue**
  - At the clock edge, if the FIFO is non-empty: `din` ← head, pop.
  - If the FIFO is empty: `din` ← 0 and increment `underrun_cnt`.
  - In both cases `nd` ← 1 for exactly one cycle.
  - FIFO emptiness is sampled in the issue cycle, not at the tick.
- A sample written in the same cycle as an issue on an empty FIFO is not used. That issue is zero-filled, and the sample remains queued.

## Timing

- The first `tick` occurs in the PERIOD-th consecutive cycle with `en`=1. Later ticks follow every PERIOD cycles.
- Issue latency: `nd` and the new `din` are visible the cycle after the issuing edge's cycle. With `rfd` high, `nd` is high in the cycle following each tick cycle.
- `full` and `level` reflect the pushes and pops of the previous edge, one-cycle registered.
- Counters saturate at 0xFFFF and never wrap.

## Test plan

Run all scenarios with PERIOD=8 and DEPTH=4.

- **Reset.** Assert `rst_n`=0 mid-stream with level=3 → all outputs 0 immediately (asynchronous). After release, the first `nd` comes 8 en-cycles later with `din`=0 and `underrun_cnt`=1.
- **Steady stream.** Write 0x0001..0x0004, hold `rfd`=1, assert `en` → `nd` pulses at en-cycles 9, 17, 25, 33 with `din` = 1, 2, 3, 4. The fifth pulse at cycle 41 has `din`=0 and `underrun_cnt`=1.
- **Back-pressure.** Hold `rfd`=0 from a tick for 3 cycles → no `nd`. `nd` appears one cycle after `rfd` rises, carrying the next sample; `late_cnt` stays 0.
- **Late period.** Hold `rfd`=0 for 20 cycles spanning two more ticks → `late_cnt`=2 and a single `nd` when `rfd` returns. Only one FIFO entry is consumed.
- **Overflow.** Write 5 samples back-to-back with `en`=0 → `full`=1 after 4, fifth dropped, `ovf`=1, `level`=4. A later write on the cycle of a pop while full is also dropped.
- **Enable drop.** Deassert `en` while in PEND → pending cleared, no `nd`. Re-enable → first `nd` 8 cycles later.
